// File: rtl/keypad_event_ctrl.sv
// Keypad event controller: turns scanner key reports into a Hack KBD value and a
// show-ahead FIFO of press/auto-repeat events with sticky overflow status.
module keypad_event_ctrl #(
  parameter int FIFO_DEPTH     = 8,
  parameter int REPEAT_DELAY   = 12500000,
  parameter int REPEAT_RATE    = 2500000,
  parameter int RELEASE_CYCLES = 64,
  parameter bit REPEAT_EN      = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [3:0]                    key_index,
  input  logic                          key_valid,
  input  logic                          keys_down,
  output logic [15:0]                   kbd_code,
  output logic [7:0]                    evt_code,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic                          evt_repeat,
  output logic                          overflow,
  input  logic                          overflow_clr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int MAXP = (REPEAT_DELAY > REPEAT_RATE)
                        ? ((REPEAT_DELAY > RELEASE_CYCLES) ? REPEAT_DELAY : RELEASE_CYCLES)
                        : ((REPEAT_RATE > RELEASE_CYCLES) ? REPEAT_RATE : RELEASE_CYCLES);
  localparam int CW   = $clog2(MAXP + 1);

  localparam logic [CW-1:0] DELAY_LD = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RATE_LD  = CW'(REPEAT_RATE - 1);
  // The cycle that enters RELEASING is the first low cycle, so the count ends two short.
  localparam logic [CW-1:0] REL_LAST = CW'((RELEASE_CYCLES > 1) ? RELEASE_CYCLES - 2 : 0);
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(FIFO_DEPTH);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] HELD      = 2'd1;
  localparam logic [1:0] REPEAT    = 2'd2;
  localparam logic [1:0] RELEASING = 2'd3;

  function automatic logic [7:0] key_ascii(input logic [3:0] idx);
    logic [7:0] a;
    case (idx)
      4'd0:  a = 8'h31;  4'd1:  a = 8'h32;  4'd2:  a = 8'h33;  4'd3:  a = 8'h41;
      4'd4:  a = 8'h34;  4'd5:  a = 8'h35;  4'd6:  a = 8'h36;  4'd7:  a = 8'h42;
      4'd8:  a = 8'h37;  4'd9:  a = 8'h38;  4'd10: a = 8'h39;  4'd11: a = 8'h43;
      4'd12: a = 8'h2A;  4'd13: a = 8'h30;  4'd14: a = 8'h23;  default: a = 8'h44;
    endcase
    return a;
  endfunction

  logic [1:0]    state, state_n, ret_state, ret_n;
  logic [CW-1:0] rpt_cnt, rpt_n, rel_cnt, rel_n;
  logic [7:0]    held_code, code_n;
  logic          push, push_rpt, tick;
  logic [7:0]    push_code;

  always_comb begin
    state_n  = state;
    ret_n    = ret_state;
    rpt_n    = rpt_cnt;
    rel_n    = rel_cnt;
    code_n   = held_code;
    push     = 1'b0;
    push_rpt = 1'b0;
    tick     = 1'b0;
    if (key_valid) begin
      code_n  = key_ascii(key_index);
      push    = 1'b1;
      rpt_n   = DELAY_LD;
      state_n = HELD;
    end else begin
      case (state)
        HELD, REPEAT: begin
          if (!keys_down) begin
            state_n = RELEASING;
            ret_n   = state;
            rel_n   = '0;
          end else begin
            tick = 1'b1;
          end
        end
        RELEASING: begin
          if (keys_down) begin
            state_n = ret_state;
            tick    = 1'b1;
          end else if (rel_cnt == REL_LAST) begin
            state_n = IDLE;
            code_n  = '0;
          end else begin
            rel_n = rel_cnt + 1'b1;
          end
        end
        default: ;
      endcase
      // Resuming from RELEASING counts that cycle, so a glitch delays repeats by exactly its length.
      if (tick && REPEAT_EN) begin
        if (rpt_cnt == '0) begin
          push     = 1'b1;
          push_rpt = 1'b1;
          rpt_n    = RATE_LD;
          state_n  = REPEAT;
        end else begin
          rpt_n = rpt_cnt - 1'b1;
        end
      end
    end
    push_code = key_valid ? key_ascii(key_index) : held_code;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ret_state <= IDLE;
      rpt_cnt   <= '0;
      rel_cnt   <= '0;
      held_code <= '0;
    end else begin
      state     <= state_n;
      ret_state <= ret_n;
      rpt_cnt   <= rpt_n;
      rel_cnt   <= rel_n;
      held_code <= code_n;
    end
  end

  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          empty, full, pop, accept, drop;

  assign empty  = (count == '0);
  assign full   = (count == FULL_LVL);
  assign pop    = evt_ready && !empty;
  assign accept = push && (!full || pop);
  assign drop   = push && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)              overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= {push_rpt, push_code};
  end

  assign kbd_code   = {8'h00, held_code};
  assign evt_valid  = !empty;
  assign evt_code   = empty ? 8'h00 : mem[rd_ptr][7:0];
  assign evt_repeat = !empty && mem[rd_ptr][8];
  assign fifo_level = count;

endmodule

// File: tb/tb_keypad_event_ctrl.sv
// Directed bench for keypad_event_ctrl: one repeat-enabled instance (depth 8) and
// one repeat-disabled instance (depth 4) share stimulus; each task checks one of them.
module tb_keypad_event_ctrl;
  logic clk = 1'b0;
  logic rst_n, key_valid, keys_down, evt_ready, overflow_clr;
  logic [3:0] key_index;

  logic [15:0] kbd_a, kbd_b;
  logic [7:0]  code_a, code_b;
  logic        valid_a, valid_b, rep_a, rep_b, ovf_a, ovf_b;
  logic [3:0]  lvl_a;
  logic [2:0]  lvl_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  keypad_event_ctrl #(.FIFO_DEPTH(8), .REPEAT_DELAY(10), .REPEAT_RATE(4),
                      .RELEASE_CYCLES(64), .REPEAT_EN(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .key_index(key_index), .key_valid(key_valid),
    .keys_down(keys_down), .kbd_code(kbd_a), .evt_code(code_a), .evt_valid(valid_a),
    .evt_ready(evt_ready), .evt_repeat(rep_a), .overflow(ovf_a),
    .overflow_clr(overflow_clr), .fifo_level(lvl_a));

  keypad_event_ctrl #(.FIFO_DEPTH(4), .REPEAT_DELAY(10), .REPEAT_RATE(4),
                      .RELEASE_CYCLES(64), .REPEAT_EN(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .key_index(key_index), .key_valid(key_valid),
    .keys_down(keys_down), .kbd_code(kbd_b), .evt_code(code_b), .evt_valid(valid_b),
    .evt_ready(evt_ready), .evt_repeat(rep_b), .overflow(ovf_b),
    .overflow_clr(overflow_clr), .fifo_level(lvl_b));

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0; key_valid = 1'b0; keys_down = 1'b0; key_index = '0;
    evt_ready = 1'b0; overflow_clr = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic press(input logic [3:0] idx);
    key_index = idx; key_valid = 1'b1; keys_down = 1'b1;
    step(1);
    key_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; key_valid = 1'b0; keys_down = 1'b0; key_index = '0;
    evt_ready = 1'b0; overflow_clr = 1'b0;
    #1;
    checks++;
    if ({kbd_a, code_a, valid_a, rep_a, ovf_a, lvl_a} !== 32'd0) begin
      errors++; $display("FAIL reset_a outputs=%h required 0", {kbd_a, code_a, valid_a, rep_a, ovf_a, lvl_a});
    end
    checks++;
    if ({kbd_b, code_b, valid_b, rep_b, ovf_b, lvl_b} !== 31'd0) begin
      errors++; $display("FAIL reset_b outputs=%h required 0", {kbd_b, code_b, valid_b, rep_b, ovf_b, lvl_b});
    end
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic test_press_release();
    reset_dut();
    press(4'd13);
    keys_down = 1'b0;
    checks++;
    if (kbd_a !== 16'h0030) begin errors++; $display("FAIL press_kbd got %h required 0030", kbd_a); end
    checks++;
    if ({valid_a, code_a, rep_a} !== {1'b1, 8'h30, 1'b0}) begin
      errors++; $display("FAIL press_evt got v=%b c=%h r=%b required v=1 c=30 r=0", valid_a, code_a, rep_a);
    end
    step(63);
    checks++;
    if (kbd_a !== 16'h0030) begin errors++; $display("FAIL release_63 got %h required 0030", kbd_a); end
    step(1);
    checks++;
    if (kbd_a !== 16'h0000) begin errors++; $display("FAIL release_64 got %h required 0000", kbd_a); end
    checks++;
    if (lvl_a !== 4'd1) begin errors++; $display("FAIL release_level got %0d required 1", lvl_a); end
    evt_ready = 1'b1;
    step(1);
    evt_ready = 1'b0;
    checks++;
    if ({valid_a, lvl_a} !== 5'd0) begin errors++; $display("FAIL pop_empty got v=%b l=%0d required 0 0", valid_a, lvl_a); end
    step(1);
    checks++;
    if ({valid_a, lvl_a} !== 5'd0) begin errors++; $display("FAIL pop_when_empty got v=%b l=%0d required 0 0", valid_a, lvl_a); end
  endtask

  task automatic test_repeat();
    reset_dut();
    press(4'd3);
    step(9);
    checks++;
    if (lvl_a !== 4'd1) begin errors++; $display("FAIL rpt_before_first got %0d required 1", lvl_a); end
    step(1);
    checks++;
    if (lvl_a !== 4'd2) begin errors++; $display("FAIL rpt_first got %0d required 2", lvl_a); end
    step(19);
    checks++;
    if (lvl_a !== 4'd6) begin errors++; $display("FAIL rpt_level got %0d required 6", lvl_a); end
    evt_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({valid_a, code_a, rep_a} !== {1'b1, 8'h41, (i != 0)}) begin
        errors++; $display("FAIL rpt_entry%0d got v=%b c=%h r=%b required v=1 c=41 r=%0d", i, valid_a, code_a, rep_a, (i != 0));
      end
      step(1);
    end
    evt_ready = 1'b0;
  endtask

  task automatic test_glitch();
    reset_dut();
    press(4'd0);
    step(3);
    keys_down = 1'b0;
    step(10);
    keys_down = 1'b1;
    checks++;
    if ({kbd_a, lvl_a} !== {16'h0031, 4'd1}) begin
      errors++; $display("FAIL glitch_hold got kbd=%h l=%0d required 0031 1", kbd_a, lvl_a);
    end
    step(6);
    checks++;
    if (lvl_a !== 4'd1) begin errors++; $display("FAIL glitch_early got %0d required 1", lvl_a); end
    step(1);
    checks++;
    if ({lvl_a, code_a, rep_a} !== {4'd2, 8'h31, 1'b0}) begin
      errors++; $display("FAIL glitch_shift got l=%0d c=%h r=%b required 2 31 0", lvl_a, code_a, rep_a);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_codes [4];
    exp_codes = '{8'h31, 8'h32, 8'h33, 8'h41};
    reset_dut();
    for (int i = 0; i < 6; i++) press(4'(i));
    checks++;
    if ({lvl_b, ovf_b} !== {3'd4, 1'b1}) begin
      errors++; $display("FAIL ovf_full got l=%0d o=%b required 4 1", lvl_b, ovf_b);
    end
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({valid_b, code_b} !== {1'b1, exp_codes[i]}) begin
        errors++; $display("FAIL ovf_pop%0d got v=%b c=%h required 1 %h", i, valid_b, code_b, exp_codes[i]);
      end
      step(1);
    end
    evt_ready = 1'b0;
    checks++;
    if ({valid_b, ovf_b} !== 2'b01) begin errors++; $display("FAIL ovf_sticky got v=%b o=%b required 0 1", valid_b, ovf_b); end
    overflow_clr = 1'b1;
    step(1);
    overflow_clr = 1'b0;
    checks++;
    if (ovf_b !== 1'b0) begin errors++; $display("FAIL ovf_clr got %b required 0", ovf_b); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_codes [4];
    exp_codes = '{8'h42, 8'h37, 8'h38, 8'h39};
    reset_dut();
    for (int i = 6; i < 10; i++) press(4'(i));
    checks++;
    if ({lvl_b, ovf_b, code_b} !== {3'd4, 1'b0, 8'h36}) begin
      errors++; $display("FAIL b2b_full got l=%0d o=%b c=%h required 4 0 36", lvl_b, ovf_b, code_b);
    end
    evt_ready = 1'b1;
    press(4'd10);
    evt_ready = 1'b0;
    checks++;
    if ({lvl_b, ovf_b} !== {3'd4, 1'b0}) begin
      errors++; $display("FAIL b2b_pushpop got l=%0d o=%b required 4 0", lvl_b, ovf_b);
    end
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({valid_b, code_b} !== {1'b1, exp_codes[i]}) begin
        errors++; $display("FAIL b2b_pop%0d got v=%b c=%h required 1 %h", i, valid_b, code_b, exp_codes[i]);
      end
      step(1);
    end
    evt_ready = 1'b0;
  endtask

  task automatic test_reset_mid_hold();
    reset_dut();
    press(4'd14);
    step(2);
    checks++;
    if (kbd_a !== 16'h0023) begin errors++; $display("FAIL hold_kbd got %h required 0023", kbd_a); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({kbd_a, lvl_a, valid_a} !== 21'd0) begin
      errors++; $display("FAIL midreset got kbd=%h l=%0d v=%b required 0 0 0", kbd_a, lvl_a, valid_a);
    end
    step(1);
    rst_n = 1'b1;
    step(20);
    checks++;
    if ({kbd_a, lvl_a} !== 20'd0) begin
      errors++; $display("FAIL midreset_after got kbd=%h l=%0d required 0 0", kbd_a, lvl_a);
    end
  endtask

  initial begin
    test_reset();
    test_press_release();
    test_repeat();
    test_glitch();
    test_overflow();
    test_back_to_back();
    test_reset_mid_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_event_ctrl.md
Name: keypad_event_ctrl

Overview:
- Sits between the 4x4 keypad scanner and the Hack CPU memory map.
- Turns the scanner's one-cycle key reports into two outputs:
  - a Hack-style KBD register value: the code of the held key, or 0 when no key is held;
  - a buffered stream of key-press events, including typematic auto-repeat, for software that must not miss presses.
- Owns press/release tracking, release debounce, repeat timing, event FIFO arbitration and the overflow status.

Parameters:
- FIFO_DEPTH, 8, event FIFO entries; power of two, 2..64.
- REPEAT_DELAY, 12500000, cycles from press acceptance to the first repeat event.
- REPEAT_RATE, 2500000, cycles between subsequent repeat events.
- RELEASE_CYCLES, 64, consecutive cycles keys_down must be low before a release is declared.
- REPEAT_EN, 1, 0 disables auto-repeat entirely.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- key_index  in  4  scanner key index, row*4+col; valid only with key_valid.
- key_valid  in  1  one-cycle pulse from the scanner: new key detected.
- keys_down  in  1  OR of all keypad rows; high while any key is physically closed.
- kbd_code  out  16  Hack KBD value: ASCII code of the held key, else 0.
- evt_code  out  8  ASCII code at the FIFO head.
- evt_valid  out  1  FIFO non-empty.
- evt_ready  in  1  consumer pop; a pop happens when evt_valid && evt_ready.
- evt_repeat  out  1  head entry is an auto-repeat, not an initial press.
- overflow  out  1  sticky flag: an event was dropped because the FIFO was full.
- overflow_clr  in  1  clears overflow; a drop in the same cycle wins and keeps it set.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current entry count.

Behaviour:
- Reset (async, rst_n=0): all outputs go to 0, FSM goes to IDLE, FIFO empties, counters clear.
- Key map, index 0..15: '1','2','3','A','4','5','6','B','7','8','9','C','*','0','#','D'.
  - kbd_code = {8'h00, ascii}.
- FSM states: IDLE, HELD, REPEAT, RELEASING.
- IDLE, key_valid=1:
  - latch the code;
  - kbd_code updates on the next edge (latency 1);
  - push a press event (repeat=0);
  - load the repeat counter with REPEAT_DELAY-1;
  - go to HELD.
- HELD:
  - the counter decrements each cycle.
  - At 0 with REPEAT_EN=1: push a repeat event (repeat=1), reload with REPEAT_RATE-1, go to REPEAT.
  - With REPEAT_EN=0 the counter is ignored.
- REPEAT: each counter expiry pushes a repeat event and reloads with REPEAT_RATE-1.
- HELD or REPEAT with keys_down=0: go to RELEASING and clear the release counter. The repeat counter freezes.
- RELEASING:
  - keys_down=1 before RELEASE_CYCLES: return to the previous state (HELD or REPEAT) and resume the frozen counter.
  - RELEASE_CYCLES consecutive low cycles: kbd_code goes to 0 on the next edge, go to IDLE.
- key_valid in HELD, REPEAT or RELEASING (a different key):
  - treat it as a new press: update the code, push a press event, reload REPEAT_DELAY-1, go to HELD;
  - this has priority over a repeat expiry in the same cycle.
- key_valid in the same cycle that the release completes: the press wins (go to HELD, kbd_code = new code).
- FIFO: show-ahead, so evt_code and evt_repeat reflect the head whenever evt_valid=1.
  - Push into an empty FIFO: evt_valid=1 on the next edge.
  - Pop with evt_valid=0: ignored.
  - Push and pop in the same cycle:
    - not empty: level unchanged, both take effect;
    - full: the pop frees a slot, the push is accepted, no overflow.
  - Push when full without a pop: the event is dropped, the FIFO is unchanged, overflow=1.
- Pointers wrap modulo FIFO_DEPTH. fifo_level saturates at FIFO_DEPTH.
- Counter widths: $clog2 of the largest parameter; no arithmetic overflow permitted.
- Reset mid-hold: all state clears immediately, kbd_code=0; the held key is not reported again until the scanner re-asserts key_valid.

Test Plan:
- Reset with inputs idle → all outputs 0; evt_valid=0, fifo_level=0.
- key_valid, index 13, keys_down=1 → next cycle kbd_code=16'h0030 and evt_code=8'h30, evt_repeat=0. keys_down low for 64 cycles → kbd_code=0 exactly after the 64th cycle.
- REPEAT_DELAY=10, REPEAT_RATE=4, key index 3 held for 30 cycles with no pops:
  - fifo_level=6 ('A' press, then repeats at cycles 10, 14, 18, 22, 26);
  - the repeat entries read evt_repeat=1.
- Glitch: keys_down low for 10 cycles mid-hold → kbd_code unchanged, repeat timing shifted by 10 cycles, no extra press event.
- FIFO_DEPTH=4, six presses with no pops:
  - fifo_level=4 and overflow=1;
  - popping returns the first four codes in order;
  - overflow_clr=1 clears overflow.
- FIFO full, push and pop in the same cycle → level stays 4, overflow stays 0, the new code lands at the tail.
